hazard_ctrl: RTL
================

# hazard_ctrl

Pipeline hazard controller for the 16-bit, 8-register MIPS pipeline. It drives the 2-bit `stall` code into the ID/EX register, the PC and IF/ID write enables, the IF/ID flush, and the EX-stage operand forwarding selects. It detects load-use hazards and sequences taken-branch flushes with a small state machine, so the pipeline registers stay simple and stateless.

## Interface
Parameters:
- `BRANCH_PENALTY`, default 2: bubble cycles inserted per taken branch, counting the resolve cycle. Legal range 1–7.

Ports:
- `clk`  in  1  rising-edge clock
- `rst`  in  1  reset; synchronous, active-high
- `id_rs`, `id_rt`  in  3 each  source registers of the instruction in ID
- `id_uses_rs`, `id_uses_rt`  in  1 each  the ID instruction actually reads that source
- `ex_rd`  in  3  destination of the instruction in EX
- `ex_load`  in  1  the instruction in EX is a load
- `mem_rd`, `mem_wb`  in  3, 1  EX/MEM destination and its write-back enable
- `wb_rd`, `wb_wb`  in  3, 1  MEM/WB destination and its write-back enable
- `branch_taken`  in  1  a taken branch or jump resolved in EX this cycle
- `pc_write`  out  1  PC update enable
- `ifid_write`  out  1  IF/ID load enable
- `ifid_flush`  out  1  IF/ID clears to a NOP
- `stall`  out  2  to ID/EX: 00 pass, 01 load-use bubble, 10 flush bubble; 11 never driven
- `fwd_a`, `fwd_b`  out  2 each  EX operand select: 00 register file, 01 EX/MEM, 10 MEM/WB; 11 never driven

## Operation
- FSM states: RUN and FLUSH, plus a 3-bit down-counter `flush_left`.
- RUN with `branch_taken`=1:
  - Outputs: `stall`=10, `ifid_flush`=1, `pc_write`=1 (target loads), `ifid_write`=1.
  - If `BRANCH_PENALTY`>1: go to FLUSH with `flush_left`=`BRANCH_PENALTY`-1.
  - If `BRANCH_PENALTY`=1: stay in RUN.
- RUN without a branch, load-use hazard present:
  - Hazard condition: `ex_load`=1, `ex_rd`≠0, and (`id_uses_rs` with `id_rs`==`ex_rd`, or `id_uses_rt` with `id_rt`==`ex_rd`).
  - Outputs: `stall`=01, `pc_write`=0, `ifid_write`=0, `ifid_flush`=0.
  - Stays in RUN. The next cycle ID/EX holds a bubble with `ex_load`=0, so the hazard clears on its own.
- RUN, no hazard: `stall`=00, `pc_write`=1, `ifid_write`=1, `ifid_flush`=0.
- FLUSH:
  - Outputs: `stall`=10, `ifid_flush`=1, `pc_write`=1, `ifid_write`=1.
  - `flush_left` decrements each cycle; return to RUN when it reaches 1.
  - `branch_taken` in FLUSH reloads `flush_left` to `BRANCH_PENALTY`-1. It is not expected, but the behaviour is defined.
  - Load-use detection is ignored in FLUSH.
- Priority: `branch_taken` > load-use > pass.
- Forwarding (combinational, evaluated per operand, A from rs and B from rt):
  - EX/MEM is selected if `mem_wb`=1, `mem_rd`≠0 and `mem_rd` equals the source.
  - Otherwise MEM/WB is selected under the same rule using `wb_wb` and `wb_rd`.
  - Otherwise 00.
  - R0 is hardwired zero and is never forwarded.
  - EX/MEM wins when both stages match.

## Timing
- While `rst`=1:
  - Outputs: `pc_write`=0, `ifid_write`=0, `ifid_flush`=1, `stall`=10, `fwd_a`=`fwd_b`=00.
  - Next state RUN, `flush_left`=0, perf counters cleared.
- First cycle after `rst` falls: RUN behaviour.
- `rst` asserted in FLUSH: the flush is abandoned; RUN next cycle.
- All hazard outputs are combinational from the inputs and the current state, with zero latency. Only the state and counters are registered.
- Load-use penalty: exactly 1 cycle.
- Branch penalty: exactly `BRANCH_PENALTY` cycles of `stall`=10, the first being the resolve cycle.

## Configuration
- `HAZ_PERF_EN` defined: adds outputs `perf_lu_stalls[15:0]` and `perf_flush_cycles[15:0]`.
  - `perf_lu_stalls` increments on each cycle with `stall`=01.
  - `perf_flush_cycles` increments on each cycle with `stall`=10 outside reset.
  - Both saturate at 16'hFFFF and clear on `rst`.
- `HAZ_PERF_EN` undefined: the ports and counters are absent. Hazard behaviour is identical in both builds.

## Structure
- Shared package `haz_pkg` holds:
  - `stall` encodings STALL_NONE, STALL_LU, STALL_FLUSH
  - `fwd` encodings FWD_RF, FWD_MEM, FWD_WB
  - FSM state typedef `haz_state_t`
- Sub-module `fwd_sel`: combinational forwarding-priority logic, instantiated twice (A and B).

## Test plan
- Reset: hold `rst` 3 cycles → `stall`=10, `pc_write`=0, `ifid_flush`=1; first cycle after → `stall`=00, `pc_write`=1.
- Load-use: `ex_load`=1, `ex_rd`=3, `id_rs`=3, `id_uses_rs`=1 → one cycle `stall`=01, `pc_write`=0, `ifid_write`=0; next cycle with `ex_load`=0 → `stall`=00.
- R0 and priority: `mem_rd`=`wb_rd`=5 with both WB enables set, `id_rt`=5 → `fwd_b`=01; the same with `mem_rd`=0 → `fwd_b`=10; `ex_rd`=0 load → no stall.
- Branch with `BRANCH_PENALTY`=2: `branch_taken` for 1 cycle → `stall`=10 and `ifid_flush`=1 for exactly 2 cycles, then 00; a simultaneous load-use hazard is ignored.
- Mid-flush reset: with `BRANCH_PENALTY`=4, assert `rst` in flush cycle 2 → after release, `stall`=00 immediately.
- `HAZ_PERF_EN`: 3 load-use stalls plus one penalty-2 branch → `perf_lu_stalls`=3, `perf_flush_cycles`=2; preload near saturation → the counter holds at FFFF.

Source files
------------

// File: rtl/haz_pkg.sv
// Shared encodings for the pipeline hazard controller: stall codes, forward selects, FSM state.
// Types only; no logic.
// Used by hazard_ctrl and fwd_sel.
package haz_pkg;

  localparam int REG_W = 3;

  typedef enum logic [1:0] {
    STALL_NONE  = 2'b00,
    STALL_LU    = 2'b01,
    STALL_FLUSH = 2'b10
  } stall_t;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_MEM = 2'b01,
    FWD_WB  = 2'b10
  } fwd_t;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } haz_state_t;

endpackage

// File: rtl/hazard_ctrl_fwd_sel.sv
// Forwarding select for one EX operand; EX/MEM beats MEM/WB, R0 never forwarded.
// Latency: combinational, zero cycles.
// Backpressure: none, pure select logic.
module fwd_sel
  import haz_pkg::*;
(
  input  logic [REG_W-1:0] src,
  input  logic [REG_W-1:0] mem_rd,
  input  logic             mem_wb,
  input  logic [REG_W-1:0] wb_rd,
  input  logic             wb_wb,
  output logic [1:0]       sel
);

  always_comb begin
    sel = FWD_RF;
    if (mem_wb && (mem_rd != '0) && (mem_rd == src)) begin
      sel = FWD_MEM;
    end else if (wb_wb && (wb_rd != '0) && (wb_rd == src)) begin
      sel = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller: load-use stall, taken-branch flush sequencing, EX forwarding. Optional HAZ_PERF_EN adds perf counters.
// Latency: all hazard outputs combinational from inputs and current state; only state/counters registered.
// Backpressure: stalls the front end itself via pc_write/ifid_write and the stall code.
module hazard_ctrl
  import haz_pkg::*;
#(
  parameter int unsigned BRANCH_PENALTY = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_load,
  input  logic [REG_W-1:0] mem_rd,
  input  logic             mem_wb,
  input  logic [REG_W-1:0] wb_rd,
  input  logic             wb_wb,
  input  logic             branch_taken,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic [1:0]       stall,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b
`ifdef HAZ_PERF_EN
  ,
  output logic [15:0]      perf_lu_stalls,
  output logic [15:0]      perf_flush_cycles
`endif
);

  localparam logic [2:0] RELOAD = 3'(BRANCH_PENALTY - 1);

  haz_state_t state_q, state_d;
  logic [2:0] flush_left_q, flush_left_d;
  logic       lu_hazard;
  logic [1:0] fwd_a_raw, fwd_b_raw;

  assign lu_hazard = ex_load && (ex_rd != '0) &&
                     ((id_uses_rs && (id_rs == ex_rd)) || (id_uses_rt && (id_rt == ex_rd)));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_RUN;
      flush_left_q <= '0;
    end else begin
      state_q      <= state_d;
      flush_left_q <= flush_left_d;
    end
  end

  // flush_left counts the bubbles still owed after the current cycle
  always_comb begin
    state_d      = state_q;
    flush_left_d = flush_left_q;
    unique case (state_q)
      ST_RUN: begin
        if (branch_taken && (BRANCH_PENALTY > 1)) begin
          state_d      = ST_FLUSH;
          flush_left_d = RELOAD;
        end
      end
      ST_FLUSH: begin
        if (branch_taken) begin
          flush_left_d = RELOAD;
        end else if (flush_left_q <= 3'd1) begin
          state_d      = ST_RUN;
          flush_left_d = '0;
        end else begin
          flush_left_d = flush_left_q - 3'd1;
        end
      end
      default: begin
        state_d      = ST_RUN;
        flush_left_d = '0;
      end
    endcase
  end

  always_comb begin
    stall      = STALL_NONE;
    pc_write   = 1'b1;
    ifid_write = 1'b1;
    ifid_flush = 1'b0;
    if (rst) begin
      stall      = STALL_FLUSH;
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      ifid_flush = 1'b1;
    end else if (branch_taken || (state_q == ST_FLUSH)) begin
      stall      = STALL_FLUSH;
      ifid_flush = 1'b1;
    end else if (lu_hazard) begin
      stall      = STALL_LU;
      pc_write   = 1'b0;
      ifid_write = 1'b0;
    end
  end

  fwd_sel u_fwd_a (
    .src    (id_rs),
    .mem_rd (mem_rd),
    .mem_wb (mem_wb),
    .wb_rd  (wb_rd),
    .wb_wb  (wb_wb),
    .sel    (fwd_a_raw)
  );

  fwd_sel u_fwd_b (
    .src    (id_rt),
    .mem_rd (mem_rd),
    .mem_wb (mem_wb),
    .wb_rd  (wb_rd),
    .wb_wb  (wb_wb),
    .sel    (fwd_b_raw)
  );

  assign fwd_a = rst ? 2'(FWD_RF) : fwd_a_raw;
  assign fwd_b = rst ? 2'(FWD_RF) : fwd_b_raw;

`ifdef HAZ_PERF_EN
  logic [15:0] perf_lu_q, perf_fl_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_lu_q <= '0;
      perf_fl_q <= '0;
    end else begin
      if ((stall == STALL_LU) && (perf_lu_q != 16'hFFFF)) perf_lu_q <= perf_lu_q + 16'd1;
      if ((stall == STALL_FLUSH) && (perf_fl_q != 16'hFFFF)) perf_fl_q <= perf_fl_q + 16'd1;
    end
  end

  assign perf_lu_stalls    = perf_lu_q;
  assign perf_flush_cycles = perf_fl_q;
`endif

endmodule
